uart_udp_packer: RTL and testbench
==================================

UART_UDP_PACKER -- requirements
Module: uart_udp_packer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 100000, meaning idle clk cycles after the last byte before a partial frame is sent (legal range 1..2^24-1).
REQ-002 SHALL have parameter MAX_BYTES, default 8, meaning payload bytes per frame (fixed to 8 to match a 64-bit data bus).
REQ-003 SHALL have port clk, input, 1, meaning the 100MHz system clock; all logic is in this one clock domain.
REQ-004 SHALL have port rstn, input, 1, meaning the reset, which is synchronous and active-low.
REQ-005 SHALL have port byte_data, input, 8, meaning the received byte.
REQ-006 SHALL have port byte_valid, input, 1, meaning a one-cycle strobe that byte_data is valid (the UART receiver ready).
REQ-007 SHALL have port flush, input, 1, meaning a level request to send the pending partial frame now.
REQ-008 SHALL have port eth_ready, input, 1, meaning the transmitter is idle and accepts send.
REQ-009 SHALL have port data, output, 64, meaning the frame payload.
REQ-010 SHALL have port size, output, 4, meaning the valid byte count, 1..8.
REQ-011 SHALL have port send, output, 1, meaning a one-cycle frame request to the transmitter.
REQ-012 SHALL have port busy, output, 1, meaning high in the SEND, WAIT_ACK and WAIT_DONE states.
REQ-013 SHALL have port overflow, output, 1, meaning a sticky flag for a dropped byte.

Function
REQ-014 SHALL implement the states IDLE, FILL, SEND, WAIT_ACK and WAIT_DONE.
REQ-015 SHALL pack bytes MSB-first: byte k (0-based) goes to data[63-8k -: 8]; unfilled bytes SHALL be 0.
REQ-016 SHALL, in IDLE, on byte_valid, store the byte, set count=1, clear the timer and move to FILL.
REQ-017 SHALL, in FILL, on byte_valid, store the byte at position count, increment count and clear the timer; otherwise the timer SHALL increment by 1 per cycle.
REQ-018 SHALL leave FILL for SEND in the cycle after any of these: count reaches 8; the timer reaches TIMEOUT-1 with no byte_valid in that cycle; flush=1 with count>=1.
REQ-019 SHALL give byte_valid priority when it coincides with a timeout or flush: the byte is stored first, and the frame then includes it.
REQ-020 SHALL ignore flush in IDLE (count=0) and never emit a frame with size 0.
REQ-021 SHALL, in SEND, assert send for exactly one cycle in the first cycle with eth_ready=1, with size=count, then move to WAIT_ACK.
REQ-022 SHALL, in WAIT_ACK, move to WAIT_DONE when eth_ready=0.
REQ-023 SHALL, in WAIT_ACK, pulse send again and stay in WAIT_ACK if eth_ready remains 1 for 16 cycles (retry); the retry count is unbounded.
REQ-024 SHALL, in WAIT_DONE, when eth_ready=1, clear count and data and move to IDLE, or to FILL per REQ-031.
REQ-025 SHALL hold data and size stable from the SEND entry cycle until leaving WAIT_DONE.
REQ-026 SHALL, with skid disabled, drop any byte_valid in SEND, WAIT_ACK or WAIT_DONE and set overflow=1.
REQ-027 SHALL keep overflow high until reset.
REQ-028 SHALL size count as 4 bits and the timer as 24 bits, with no wrap: the timer saturates at TIMEOUT-1.

Reset
REQ-029 SHALL, when rstn=0 at a clk edge, set state=IDLE, data=0, size=0, send=0, busy=0, overflow=0, count=0, timer=0 and clear the skid register.
REQ-030 SHALL abandon any frame in progress when reset is applied mid-operation; no send is issued after rstn returns high until new bytes arrive.

Configuration
REQ-031 SHALL, with macro UART_UDP_PACKER_SKID_EN defined, add a one-byte skid register: the first byte received while busy is held; on leaving WAIT_DONE it becomes byte 0 of the next frame (count=1, state FILL, timer=0); later bytes while the skid is full are dropped and set overflow.
REQ-032 SHALL, without UART_UDP_PACKER_SKID_EN, omit the skid register and follow REQ-026.

Verification
REQ-033 SHALL cover: 8 byte_valid strobes 0x11..0x88 with eth_ready=1 -> one send pulse, data=64'h1122334455667788, size=8, busy high.
REQ-034 SHALL cover: TIMEOUT=10, bytes 0xAB,0xCD then idle -> send 10 cycles after the 2nd byte, data=64'hABCD000000000000, size=2.
REQ-035 SHALL cover: flush with no bytes pending -> no send; 1 byte 0x5A then flush -> send with size=1, data[63:56]=0x5A.
REQ-036 SHALL cover: byte sent while eth_ready is held low for 50 cycles -> send is delayed until eth_ready rises and data is stable throughout; a byte arriving during WAIT_DONE gives overflow=1 (no skid) or becomes byte 0 of the next frame (skid).
REQ-037 SHALL cover: rstn=0 during WAIT_DONE -> next cycle all outputs are 0 and state is IDLE; a later eth_ready rise causes no send.

Source files
------------

// File: rtl/uart_udp_packer_if.sv
// Byte-stream to frame packer bus: UART byte input, flush request and
// Ethernet transmitter handshake.
interface uart_udp_packer_if;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        flush;
    logic        eth_ready;
    logic [63:0] data;
    logic [3:0]  size;
    logic        send;
    logic        busy;
    logic        overflow;

    // Stimulus side: drives bytes, flush and transmitter readiness
    modport master (
        output byte_data, byte_valid, flush, eth_ready,
        input  data, size, send, busy, overflow
    );

    // Packer side
    modport slave (
        input  byte_data, byte_valid, flush, eth_ready,
        output data, size, send, busy, overflow
    );
endinterface

// File: rtl/uart_udp_packer.sv
// Packs UART bytes MSB-first into 64-bit frames and hands each frame to an
// Ethernet transmitter. A frame goes out when full, after TIMEOUT idle cycles,
// or on flush. Optional one-byte skid buffer: UART_UDP_PACKER_SKID_EN.
module uart_udp_packer #(
    parameter int unsigned TIMEOUT   = 100000,
    parameter int unsigned MAX_BYTES = 8
) (
    input logic               clk,
    input logic               rstn,
    uart_udp_packer_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StSend,
        StWaitAck,
        StWaitDone
    } state_e;

    localparam logic [23:0] TimerMax  = 24'(TIMEOUT - 1);
    localparam logic [3:0]  LastCount = 4'(MAX_BYTES - 1);

    state_e      r_state, w_state_next;
    logic [63:0] r_data, w_data_next;
    logic [3:0]  r_count, w_count_next;
    logic [23:0] r_timer, w_timer_next;
    logic [3:0]  r_ack_cnt, w_ack_cnt_next;
    logic        r_overflow, w_overflow_next;
    logic        w_send;
    logic        w_busy;
`ifdef UART_UDP_PACKER_SKID_EN
    logic        r_skid_full, w_skid_full_next;
    logic [7:0]  r_skid_byte, w_skid_byte_next;
`endif

    assign w_busy = (r_state == StSend) || (r_state == StWaitAck) || (r_state == StWaitDone);

    // Next-state, frame assembly and handshake outputs
    always_comb begin
        w_state_next    = r_state;
        w_data_next     = r_data;
        w_count_next    = r_count;
        w_timer_next    = r_timer;
        w_ack_cnt_next  = r_ack_cnt;
        w_overflow_next = r_overflow;
        w_send          = 1'b0;
`ifdef UART_UDP_PACKER_SKID_EN
        w_skid_full_next = r_skid_full;
        w_skid_byte_next = r_skid_byte;
        // First byte while busy is parked; any further one is lost
        if (w_busy && bus.byte_valid) begin
            if (!r_skid_full) begin
                w_skid_full_next = 1'b1;
                w_skid_byte_next = bus.byte_data;
            end else begin
                w_overflow_next = 1'b1;
            end
        end
`else
        if (w_busy && bus.byte_valid) begin
            w_overflow_next = 1'b1;
        end
`endif

        unique case (r_state)
            StIdle: begin
                // flush is ignored here so an empty frame can never be sent
                if (bus.byte_valid) begin
                    w_data_next[63:56] = bus.byte_data;
                    w_count_next       = 4'd1;
                    w_timer_next       = '0;
                    w_state_next       = StFill;
                end
            end
            StFill: begin
                if (bus.byte_valid) begin
                    // A byte wins over timeout/flush and is part of the frame
                    for (int k = 0; k < 8; k++) begin
                        if (r_count == 4'(k)) begin
                            w_data_next[63 - 8*k -: 8] = bus.byte_data;
                        end
                    end
                    w_count_next = r_count + 4'd1;
                    w_timer_next = '0;
                    if ((r_count == LastCount) || bus.flush) begin
                        w_state_next = StSend;
                    end
                end else if ((r_timer == TimerMax) || bus.flush) begin
                    w_timer_next = '0;
                    w_state_next = StSend;
                end else begin
                    w_timer_next = r_timer + 24'd1;
                end
            end
            StSend: begin
                if (bus.eth_ready) begin
                    w_send         = 1'b1;
                    w_ack_cnt_next = '0;
                    w_state_next   = StWaitAck;
                end
            end
            StWaitAck: begin
                if (!bus.eth_ready) begin
                    w_ack_cnt_next = '0;
                    w_state_next   = StWaitDone;
                end else if (r_ack_cnt == 4'd15) begin
                    // Transmitter never went busy: request the frame again
                    w_send         = 1'b1;
                    w_ack_cnt_next = '0;
                end else begin
                    w_ack_cnt_next = r_ack_cnt + 4'd1;
                end
            end
            StWaitDone: begin
                if (bus.eth_ready) begin
                    w_data_next  = '0;
                    w_count_next = '0;
                    w_timer_next = '0;
                    w_state_next = StIdle;
`ifdef UART_UDP_PACKER_SKID_EN
                    // Includes a byte parked in this very cycle
                    if (w_skid_full_next) begin
                        w_data_next[63:56] = w_skid_byte_next;
                        w_count_next       = 4'd1;
                        w_skid_full_next   = 1'b0;
                        w_state_next       = StFill;
                    end
`endif
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_data      <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_ack_cnt   <= '0;
            r_overflow  <= 1'b0;
`ifdef UART_UDP_PACKER_SKID_EN
            r_skid_full <= 1'b0;
            r_skid_byte <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_data      <= w_data_next;
            r_count     <= w_count_next;
            r_timer     <= w_timer_next;
            r_ack_cnt   <= w_ack_cnt_next;
            r_overflow  <= w_overflow_next;
`ifdef UART_UDP_PACKER_SKID_EN
            r_skid_full <= w_skid_full_next;
            r_skid_byte <= w_skid_byte_next;
`endif
        end
    end

    assign bus.data     = r_data;
    assign bus.size     = r_count;
    assign bus.send     = w_send;
    assign bus.busy     = w_busy;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_udp_packer.sv
// Directed bench for uart_udp_packer built with TIMEOUT=10.
module tb_uart_udp_packer;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    uart_udp_packer_if u_if ();

    uart_udp_packer #(
        .TIMEOUT   (10),
        .MAX_BYTES (8)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if.slave)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are observed 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn             = 1'b0;
        u_if.byte_data   = 8'h00;
        u_if.byte_valid  = 1'b0;
        u_if.flush       = 1'b0;
        u_if.eth_ready   = 1'b1;
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.byte_valid = 1'b1;
        u_if.byte_data  = b;
        cyc();
        u_if.byte_valid = 1'b0;
    endtask

    // From SEND with eth_ready=1: ack, transmitter busy, transmitter done
    task automatic finish_frame();
        cyc();
        u_if.eth_ready = 1'b0;
        cyc();
        u_if.eth_ready = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (u_if.data !== 64'h0) begin failures++; $display("FAIL reset_data: got %h want 0", u_if.data); end
        checks++; if (u_if.size !== 4'd0) begin failures++; $display("FAIL reset_size: got %0d want 0", u_if.size); end
        checks++; if (u_if.send !== 1'b0) begin failures++; $display("FAIL reset_send: got %b want 0", u_if.send); end
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
        checks++; if (u_if.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", u_if.overflow); end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            u_if.byte_valid = 1'b1;
            u_if.byte_data  = 8'((i + 1) * 8'h11);
            cyc();
        end
        u_if.byte_valid = 1'b0;
        checks++; if (u_if.send !== 1'b1) begin failures++; $display("FAIL full_send: got %b want 1", u_if.send); end
        checks++; if (u_if.data !== 64'h1122334455667788) begin failures++; $display("FAIL full_data: got %h want 1122334455667788", u_if.data); end
        checks++; if (u_if.size !== 4'd8) begin failures++; $display("FAIL full_size: got %0d want 8", u_if.size); end
        checks++; if (u_if.busy !== 1'b1) begin failures++; $display("FAIL full_busy: got %b want 1", u_if.busy); end
        cyc();
        checks++; if (u_if.send !== 1'b0) begin failures++; $display("FAIL full_single_pulse: got %b want 0", u_if.send); end
        u_if.eth_ready = 1'b0;
        cyc();
        u_if.eth_ready = 1'b1;
        cyc();
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL full_done_busy: got %b want 0", u_if.busy); end
        checks++; if ({u_if.data, u_if.size} !== 68'h0) begin failures++; $display("FAIL full_done_clear: got %h/%0d want 0/0", u_if.data, u_if.size); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        send_byte(8'hAB);
        send_byte(8'hCD);
        n = 0;
        while (u_if.send !== 1'b1 && n < 30) begin
            cyc();
            n++;
        end
        checks++; if (n != 10) begin failures++; $display("FAIL timeout_latency: got %0d want 10", n); end
        checks++; if (u_if.data !== 64'hABCD000000000000) begin failures++; $display("FAIL timeout_data: got %h want abcd000000000000", u_if.data); end
        checks++; if (u_if.size !== 4'd2) begin failures++; $display("FAIL timeout_size: got %0d want 2", u_if.size); end
        finish_frame();
    endtask

    task automatic test_flush();
        int n_send;
        do_reset();
        u_if.flush = 1'b1;
        n_send = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (u_if.send === 1'b1) n_send++;
        end
        u_if.flush = 1'b0;
        checks++; if (n_send != 0) begin failures++; $display("FAIL flush_empty_send: got %0d want 0", n_send); end
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL flush_empty_busy: got %b want 0", u_if.busy); end
        send_byte(8'h5A);
        u_if.flush = 1'b1;
        cyc();
        u_if.flush = 1'b0;
        checks++; if (u_if.send !== 1'b1) begin failures++; $display("FAIL flush_send: got %b want 1", u_if.send); end
        checks++; if (u_if.size !== 4'd1) begin failures++; $display("FAIL flush_size: got %0d want 1", u_if.size); end
        checks++; if (u_if.data !== 64'h5A00000000000000) begin failures++; $display("FAIL flush_data: got %h want 5a00000000000000", u_if.data); end
        finish_frame();
    endtask

    task automatic test_byte_with_flush();
        do_reset();
        send_byte(8'h10);
        u_if.byte_valid = 1'b1;
        u_if.byte_data  = 8'h20;
        u_if.flush      = 1'b1;
        cyc();
        u_if.byte_valid = 1'b0;
        u_if.flush      = 1'b0;
        checks++; if (u_if.send !== 1'b1) begin failures++; $display("FAIL coincide_send: got %b want 1", u_if.send); end
        checks++; if ({u_if.data, u_if.size} !== {64'h1020000000000000, 4'd2}) begin failures++; $display("FAIL coincide_frame: got %h/%0d want 1020000000000000/2", u_if.data, u_if.size); end
        finish_frame();
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        u_if.eth_ready = 1'b0;
        send_byte(8'h3C);
        u_if.flush = 1'b1;
        cyc();
        u_if.flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (u_if.send !== 1'b0 || u_if.busy !== 1'b1 || u_if.size !== 4'd1 ||
                u_if.data !== 64'h3C00000000000000) bad++;
            cyc();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        u_if.eth_ready = 1'b1;
        #1;
        checks++; if (u_if.send !== 1'b1) begin failures++; $display("FAIL bp_send: got %b want 1", u_if.send); end
        cyc();
        u_if.eth_ready = 1'b0;
        cyc();
        u_if.byte_valid = 1'b1;
        u_if.byte_data  = 8'h77;
        cyc();
        u_if.byte_valid = 1'b0;
        checks++; if (u_if.data !== 64'h3C00000000000000) begin failures++; $display("FAIL bp_done_data: got %h want 3c00000000000000", u_if.data); end
`ifdef UART_UDP_PACKER_SKID_EN
        checks++; if (u_if.overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow: got %b want 0", u_if.overflow); end
        u_if.eth_ready = 1'b1;
        cyc();
        checks++; if ({u_if.data, u_if.size} !== {64'h7700000000000000, 4'd1}) begin failures++; $display("FAIL bp_skid_frame: got %h/%0d want 7700000000000000/1", u_if.data, u_if.size); end
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL bp_skid_busy: got %b want 0", u_if.busy); end
`else
        checks++; if (u_if.overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b want 1", u_if.overflow); end
        u_if.eth_ready = 1'b1;
        cyc();
        checks++; if ({u_if.data, u_if.size} !== 68'h0) begin failures++; $display("FAIL bp_drop_frame: got %h/%0d want 0/0", u_if.data, u_if.size); end
        checks++; if (u_if.overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow_sticky: got %b want 1", u_if.overflow); end
`endif
    endtask

    task automatic test_retry();
        int n;
        do_reset();
        send_byte(8'h01);
        u_if.flush = 1'b1;
        cyc();
        u_if.flush = 1'b0;
        checks++; if (u_if.send !== 1'b1) begin failures++; $display("FAIL retry_first: got %b want 1", u_if.send); end
        cyc();
        n = 1;
        while (u_if.send !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        checks++; if (n != 16) begin failures++; $display("FAIL retry_gap: got %0d want 16", n); end
        u_if.eth_ready = 1'b0;
        cyc();
        u_if.eth_ready = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid();
        int n_send;
        do_reset();
        send_byte(8'h99);
        u_if.flush = 1'b1;
        cyc();
        u_if.flush = 1'b0;
        cyc();
        u_if.eth_ready = 1'b0;
        cyc();
        checks++; if (u_if.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b want 1", u_if.busy); end
        rstn = 1'b0;
        cyc();
        checks++; if ({u_if.data, u_if.size, u_if.send, u_if.busy, u_if.overflow} !== 71'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h/%0d/%b/%b/%b want all 0",
                     u_if.data, u_if.size, u_if.send, u_if.busy, u_if.overflow);
        end
        rstn = 1'b1;
        u_if.eth_ready = 1'b1;
        n_send = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (u_if.send === 1'b1 || u_if.busy === 1'b1) n_send++;
        end
        checks++; if (n_send != 0) begin failures++; $display("FAIL mid_no_send: got %0d want 0", n_send); end
    endtask

    initial begin
        u_if.byte_data  = 8'h00;
        u_if.byte_valid = 1'b0;
        u_if.flush      = 1'b0;
        u_if.eth_ready  = 1'b1;
        test_reset();
        test_full_frame();
        test_timeout();
        test_flush();
        test_byte_with_flush();
        test_backpressure();
        test_retry();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
